ysyx_23060072_mem_responder: RTL and testbench

Memory-side responder for the rv32e core's fetch/load-store request channel. Accepts one word-addressed read or byte-strobed write request via valid/ready handshake. Returns the response after a programmable latency, holding it until the core accepts it. Instantiated in the testbench as the memory model behind the core; it also serves as the reference for the future on-chip SRAM wrapper.

---
 rtl/ysyx_23060072_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_23060072_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060072_mem_responder
// Purpose  : Memory-side responder for the rv32e fetch/load-store channel.
//            Accepts one word-addressed read or byte-strobed write request
//            through a valid/ready handshake. It returns the response after a
//            programmable latency and holds it until the core accepts it.
//            Only one request is outstanding at a time.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            req_valid  - request present
//            req_ready  - responder can accept (high only in IDLE)
//            req_addr   - byte address
//            req_wen    - 1 = write, 0 = read
//            req_wdata  - write data
//            req_wstrb  - byte enables, bit i covers wdata[8i+7:8i]
//            rsp_valid  - response present
//            rsp_ready  - core accepts the response
//            rsp_rdata  - read data; 0 for writes and for errors
//            rsp_err    - address misaligned or out of range
// Options  : YSYX_23060072_MEM_RAND_STALL_EN - when defined, adds a random
//            0..3 cycle stall per request. The stall comes from an 8-bit
//            Fibonacci LFSR (taps 8,6,5,4) seeded with LFSR_SEED.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060072_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,  // words, power of two
    parameter int          LATENCY   = 2,     // 1..15; 0 is illegal
    parameter logic [7:0]  LFSR_SEED = 8'hA5  // must be nonzero
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_AW     = $clog2(DEPTH);
    localparam logic [31:0] c_SPAN   = 32'(DEPTH * 4);
    localparam logic [4:0]  c_LAT_M1 = 5'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    // Request copy captured at accept; the live req_* bus is ignored after it.
    logic [31:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic [31:0] mem [DEPTH];

    logic [31:0]     w_off;
    logic            w_err;
    logic [c_AW-1:0] w_idx;
    logic            w_commit;
    logic            w_wr_commit;
    logic [4:0]      w_extra;
    logic [4:0]      w_load;

    // Unsigned 32-bit wrap makes addresses below BASE_ADDR land far past the
    // end, so a single compare covers both out-of-range directions.
    assign w_off       = r_addr - BASE_ADDR;
    assign w_err       = (r_addr[1:0] != 2'b00) || (w_off >= c_SPAN);
    assign w_idx       = w_off[c_AW+1:2];
    assign w_commit    = (r_state == S_WAIT) && (r_cnt == 5'd0);
    assign w_wr_commit = w_commit && r_wen && !w_err;
    assign w_load      = c_LAT_M1 + w_extra;

`ifdef YSYX_23060072_MEM_RAND_STALL_EN
    logic [7:0] r_lfsr;

    // Free-running from reset so that the stall sequence is reproducible
    // for a given seed and request timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_extra = {3'b000, r_lfsr[1:0]};
`else
    logic [7:0] w_unused_seed;

    assign w_unused_seed = LFSR_SEED;
    assign w_extra       = 5'd0;
`endif

    // The storage array has no reset: its contents survive rst. An
    // uncommitted write is dropped because reset forces the FSM out of WAIT.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_addr      <= 32'd0;
            r_wen       <= 1'b0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_wen       <= req_wen;
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        r_cnt       <= w_load;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        // Read data is sampled here, so any earlier write
                        // commit is already visible.
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_wen) ? 32'd0 : mem[w_idx];
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060072_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060072_mem_responder
// Purpose  : Directed self-checking bench for the memory responder with
//            default parameters (BASE 0x8000_0000, DEPTH 1024, LATENCY 2).
//            Expected responses go into a scoreboard queue when a request is
//            driven, and are compared when the response appears. The bench
//            honours YSYX_23060072_MEM_RAND_STALL_EN through its own LFSR
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060072_mem_responder;

    localparam int c_LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    ysyx_23060072_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference stall generator: 8-bit Fibonacci LFSR, taps 8,6,5,4.
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request from a negedge, then waits for the response and
    // checks it against the scoreboard. With hold > 0, rsp_ready stays low
    // for that many extra cycles while stray req_valid pulses are injected.
    task automatic do_req(input string tag, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_data, input logic exp_err, input int hold);
        exp_t e;
        exp_t g;
        int   lat;
        bit   got;
        logic [31:0] held;

        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        e.data = exp_data;
        e.err  = exp_err;
`ifdef YSYX_23060072_MEM_RAND_STALL_EN
        e.lat  = c_LAT + int'(lfsr_m[1:0]);
`else
        e.lat  = c_LAT;
`endif
        sb.push_back(e);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_wstrb = wstrb;
        @(posedge clk);
        #1;
        // Scramble the bus; the responder must rely on its latched copy.
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wen   = 1'b1;
        req_wdata = $urandom;
        req_wstrb = 4'hF;

        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) begin
            chk({tag, ".rsp_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        g = sb.pop_front();
        chk({tag, ".rdata"}, rsp_rdata, g.data);
        chk({tag, ".err"}, 32'(rsp_err), 32'(g.err));
        chk({tag, ".latency"}, 32'(lat), 32'(g.lat));

        held = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
            req_valid = 1'b1;
            req_addr  = 32'h8000_0010;
            req_wen   = 1'b1;
            req_wdata = 32'h0;
            req_wstrb = 4'hF;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata, held);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        if (hold > 0) begin
            chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
            chk({tag, ".done_req_ready"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_wen   = 1'b0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'd0);
        chk("reset.rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        // Full write then read back.
        do_req("wr_full", 32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 0);
        do_req("rd_full", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);

        // Partial write: byte lanes 0 and 2 only.
        do_req("wr_part", 32'h8000_0010, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 0);
        do_req("rd_part", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 0);

        // Error addresses: misaligned, below base, one past the end.
        do_req("rd_misal", 32'h8000_0002, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        do_req("rd_below", 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        do_req("rd_past", 32'h8000_1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        do_req("wr_misal", 32'h8000_0012, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
        do_req("wr_past", 32'h8000_1010, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
        do_req("rd_after_err", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 0);

        // Backpressure: response held for 5 cycles with stray request pulses.
        do_req("rd_hold", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 5);
        do_req("rd_after_hold", 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 0);

        // Last word in range, and a no-op write with zero strobes.
        do_req("wr_last", 32'h8000_0FFC, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
        do_req("wr_nostrb", 32'h8000_0FFC, 1'b1, 32'h0000_0000, 4'h0, 32'h0, 1'b0, 0);
        do_req("rd_last", 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Reset while a write sits in WAIT: it must be dropped.
        do_req("wr_zero20", 32'h8000_0020, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wen   = 1'b1;
        req_wdata = 32'hCAFE_F00D;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid_rst.accepted", 32'(req_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst.req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_rst.rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_req("rd_after_rst", 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        do_req("rd_keep_last", 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // Latency sweep; each latency is checked against the stall model.
        for (int k = 0; k < 16; k++) begin
            do_req($sformatf("lat_rd%0d", k), 32'h8000_0010, 1'b0, 32'h0, 4'h0,
                   32'h12BB_56DD, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
